cv32e40p_register_file_secded_scrub: RTL and testbench

Parametrised SEC-DED (extended Hamming) protected flip-flop register file. It replaces the fixed 32-bit, three-read-port Hamming wrapper in the ID stage. Data width and read-port count are generalised. The block adds a background scrubber that walks the array and writes back single-bit corrections, saturating error counters, a sticky double-error record, and a fault-injection port for verification.

---
 rtl/cv32e40p_register_file_secded_scrub.sv | 207 ++++++++++++++++++++
 tb/tb_cv32e40p_register_file_secded_scrub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_register_file_secded_scrub.sv
// SEC-DED (extended Hamming) protected flip-flop register file with combinational
// correcting read ports, a background scrubber that writes back single-bit fixes, and fault injection.
module cv32e40p_register_file_secded_scrub #(
    parameter  int ADDR_WIDTH     = 5,
    parameter  int DATA_WIDTH     = 32,
    parameter  int NUM_RD_PORTS   = 3,
    parameter  int SCRUB_INTERVAL = 64,
    parameter  int CNT_WIDTH      = 16,
    localparam int P = (DATA_WIDTH <= 1)   ? 2 : (DATA_WIDTH <= 4)   ? 3 :
                       (DATA_WIDTH <= 11)  ? 4 : (DATA_WIDTH <= 26)  ? 5 :
                       (DATA_WIDTH <= 57)  ? 6 : (DATA_WIDTH <= 120) ? 7 :
                       (DATA_WIDTH <= 247) ? 8 : (DATA_WIDTH <= 502) ? 9 : 10,
    localparam int CODE_WIDTH = DATA_WIDTH + P + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               scan_cg_en_i,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RD_PORTS-1:0]            sec_o,
    output logic [NUM_RD_PORTS-1:0]            ded_o,
    input  logic [ADDR_WIDTH-1:0]              waddr_a_i,
    input  logic [DATA_WIDTH-1:0]              wdata_a_i,
    input  logic                               we_a_i,
    input  logic [ADDR_WIDTH-1:0]              waddr_b_i,
    input  logic [DATA_WIDTH-1:0]              wdata_b_i,
    input  logic                               we_b_i,
    input  logic                               scrub_en_i,
    input  logic                               inj_en_i,
    input  logic [ADDR_WIDTH-1:0]              inj_addr_i,
    input  logic [CODE_WIDTH-1:0]              inj_mask_i,
    input  logic                               clr_i,
    output logic                               scrub_busy_o,
    output logic [CNT_WIDTH-1:0]               sec_cnt_o,
    output logic [CNT_WIDTH-1:0]               ded_cnt_o,
    output logic                               ded_valid_o,
    output logic [ADDR_WIDTH-1:0]              ded_addr_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int ICW   = $clog2(SCRUB_INTERVAL + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sec;
        logic                  ded;
    } dec_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_FIX} state_t;

    function automatic logic [CODE_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] data);
        logic [CODE_WIDTH-1:0] code;
        logic [DATA_WIDTH-1:0] rem;
        code = '0;
        rem  = data;
        for (int j = 1; j < CODE_WIDTH; j++) begin
            if ((j & (j - 1)) != 0) begin
                code[j] = rem[0];
                rem     = rem >> 1;
            end
        end
        for (int i = 0; i < P; i++) begin
            for (int j = 1; j < CODE_WIDTH; j++) begin
                if ((j & (j - 1)) != 0 && (j & (1 << i)) != 0) code[1 << i] ^= code[j];
            end
        end
        code[0] = ^code[CODE_WIDTH-1:1];
        return code;
    endfunction

    // Syndrome 0 with bad parity means only the overall parity bit flipped.
    function automatic dec_t decode(input logic [CODE_WIDTH-1:0] code);
        dec_t                  res;
        logic [CODE_WIDTH-1:0] fixed;
        logic [P-1:0]          syn;
        logic                  par;
        syn = '0;
        for (int j = 1; j < CODE_WIDTH; j++) begin
            if (code[j]) syn ^= P'(j);
        end
        par   = ^code;
        fixed = code;
        res   = '0;
        if (syn != '0 && par) begin
            res.sec = 1'b1;
            for (int j = 1; j < CODE_WIDTH; j++) begin
                if (syn == P'(j)) fixed[j] = ~fixed[j];
            end
        end else if (par) begin
            res.sec = 1'b1;
        end else if (syn != '0) begin
            res.ded = 1'b1;
        end
        for (int j = 1; j < CODE_WIDTH; j++) begin
            if ((j & (j - 1)) != 0) res.data = {fixed[j], res.data[DATA_WIDTH-1:1]};
        end
        return res;
    endfunction

    logic [CODE_WIDTH-1:0] mem [DEPTH];
    logic [CODE_WIDTH-1:0] code_a, code_b, code_fix;
    logic [DATA_WIDTH-1:0] fix_data;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ICW-1:0]        interval_cnt;
    state_t                state, state_next;
    dec_t                  scrub_dec;
    logic                  func_hit, fix_we, check_act, ptr_adv, interval_done;
    logic                  unused_scan;

    assign unused_scan = scan_cg_en_i;
    assign code_a      = encode(wdata_a_i);
    assign code_b      = encode(wdata_b_i);
    assign code_fix    = encode(fix_data);

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        dec_t                  dec;
        assign addr = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign dec  = (addr == '0) ? '0 : decode(mem[addr]);
        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = dec.data;
        assign sec_o[k] = dec.sec;
        assign ded_o[k] = dec.ded;
    end

    // Functional writes beat the scrubber fix, which beats injection; entry 0 is never written.
    // NOTE: the array is reset like any other state so an async reset mid-FIX leaves no partial write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (we_b_i && waddr_b_i == ADDR_WIDTH'(i))       mem[i] <= code_b;
                else if (we_a_i && waddr_a_i == ADDR_WIDTH'(i))  mem[i] <= code_a;
                else if (fix_we && ptr == ADDR_WIDTH'(i))        mem[i] <= code_fix;
                else if (inj_en_i && inj_addr_i == ADDR_WIDTH'(i)) mem[i] <= mem[i] ^ inj_mask_i;
            end
        end
    end

    assign scrub_dec     = decode(mem[ptr]);
    assign func_hit      = (we_a_i && waddr_a_i == ptr) || (we_b_i && waddr_b_i == ptr);
    assign check_act     = (state == S_CHECK) && scrub_en_i;
    assign interval_done = (interval_cnt == ICW'(SCRUB_INTERVAL - 1));
    assign ptr_adv       = (check_act && (!scrub_dec.sec || func_hit)) || (state == S_FIX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next defaults to state so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (scrub_en_i) state_next = S_WAIT;
            S_WAIT:  if (!scrub_en_i) state_next = S_IDLE;
                     else if (interval_done) state_next = S_CHECK;
            S_CHECK: if (!scrub_en_i) state_next = S_IDLE;
                     else if (scrub_dec.sec && !func_hit) state_next = S_FIX;
                     else state_next = S_WAIT;
            S_FIX:   state_next = scrub_en_i ? S_WAIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        scrub_busy_o = (state == S_CHECK) || (state == S_FIX);
        fix_we       = (state == S_FIX) && !func_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= ADDR_WIDTH'(1);
            interval_cnt <= '0;
            fix_data     <= '0;
        end else begin
            interval_cnt <= (state == S_WAIT && scrub_en_i && !interval_done) ? interval_cnt + ICW'(1) : '0;
            if (state == S_CHECK) fix_data <= scrub_dec.data;
            if (ptr_adv)          ptr <= (&ptr) ? ADDR_WIDTH'(1) : ptr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_o   <= '0;
            ded_cnt_o   <= '0;
            ded_valid_o <= 1'b0;
            ded_addr_o  <= '0;
        end else if (clr_i) begin
            sec_cnt_o   <= '0;
            ded_cnt_o   <= '0;
            ded_valid_o <= 1'b0;
            ded_addr_o  <= '0;
        end else if (check_act) begin
            if (scrub_dec.sec && !(&sec_cnt_o)) sec_cnt_o <= sec_cnt_o + CNT_WIDTH'(1);
            if (scrub_dec.ded) begin
                if (!(&ded_cnt_o)) ded_cnt_o <= ded_cnt_o + CNT_WIDTH'(1);
                if (!ded_valid_o) begin
                    ded_valid_o <= 1'b1;
                    ded_addr_o  <= ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_register_file_secded_scrub.sv
// Scoreboard bench: expected read results are queued as reads are issued and popped once
// the combinational outputs settle; a cycle model tracks which entry each scrub visit hits.
module tb_cv32e40p_register_file_secded_scrub;

    localparam int AW = 5, DW = 32, NP = 3, CW = 39, CNTW = 2, INTERVAL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            scan_cg_en = 1'b0;
    logic [NP*AW-1:0] raddr = '0;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]   sec, ded;
    logic [AW-1:0]   waddr_a = '0, waddr_b = '0, inj_addr = '0;
    logic [DW-1:0]   wdata_a = '0, wdata_b = '0;
    logic            we_a = 1'b0, we_b = 1'b0, scrub_en = 1'b0, inj_en = 1'b0, clr = 1'b0;
    logic [CW-1:0]   inj_mask = '0;
    logic            scrub_busy, ded_valid;
    logic [CNTW-1:0] sec_cnt, ded_cnt;
    logic [AW-1:0]   ded_addr;

    always #5 clk = ~clk;

    cv32e40p_register_file_secded_scrub #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP),
        .SCRUB_INTERVAL(INTERVAL), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_cg_en_i(scan_cg_en),
        .raddr_i(raddr), .rdata_o(rdata), .sec_o(sec), .ded_o(ded),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .scrub_en_i(scrub_en), .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask),
        .clr_i(clr), .scrub_busy_o(scrub_busy), .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt),
        .ded_valid_o(ded_valid), .ded_addr_o(ded_addr)
    );

    typedef struct {
        int          port;
        string       tag;
        logic [DW-1:0] data;
        logic        sec;
        logic        ded;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      total = 0, bad = 0;
    int      mptr = 1, visit_ptr = 0;
    bit      visited = 1'b0;
    logic    busy_q = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; a rising scrub_busy marks a CHECK of the modelled pointer.
    task automatic tick();
        @(negedge clk);
        visited = 1'b0;
        if (scrub_busy && !busy_q) begin
            visit_ptr = mptr;
            visited   = 1'b1;
            mptr      = (mptr == 31) ? 1 : mptr + 1;
        end
        busy_q = scrub_busy;
    endtask

    task automatic wait_visit(input int target);
        bit found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            tick();
            if (visited && visit_ptr == target) found = 1'b1;
        end
        if (!found) check($sformatf("visit_x%0d", target), 64'(visit_ptr), 64'(target));
    endtask

    task automatic read_all(input string tag, input int addr, input logic [DW-1:0] data,
                            input logic s, input logic d);
        rd_exp_t e;
        for (int p = 0; p < NP; p++) begin
            raddr[p*AW +: AW] = AW'(addr);
            e.port = p; e.tag = $sformatf("%s.p%0d", tag, p); e.data = data; e.sec = s; e.ded = d;
            sb.push_back(e);
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".data"}, 64'(rdata[e.port*DW +: DW]), 64'(e.data));
            check({e.tag, ".sec"},  64'(sec[e.port]), 64'(e.sec));
            check({e.tag, ".ded"},  64'(ded[e.port]), 64'(e.ded));
        end
    endtask

    task automatic wr(input bit use_b, input int addr, input logic [DW-1:0] data);
        if (use_b) begin we_b = 1'b1; waddr_b = AW'(addr); wdata_b = data; end
        else       begin we_a = 1'b1; waddr_a = AW'(addr); wdata_a = data; end
        tick();
        we_a = 1'b0; we_b = 1'b0;
    endtask

    task automatic inject(input int addr, input logic [CW-1:0] mask);
        inj_en = 1'b1; inj_addr = AW'(addr); inj_mask = mask;
        tick();
        inj_en = 1'b0;
    endtask

    task automatic check_status(input string tag, input int busy, input int sc, input int dc,
                                input int dv, input int da);
        check({tag, ".busy"},      64'(scrub_busy), 64'(busy));
        check({tag, ".sec_cnt"},   64'(sec_cnt), 64'(sc));
        check({tag, ".ded_cnt"},   64'(ded_cnt), 64'(dc));
        check({tag, ".ded_valid"}, 64'(ded_valid), 64'(dv));
        check({tag, ".ded_addr"},  64'(ded_addr), 64'(da));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10;
        check_status("reset", 0, 0, 0, 0, 0);
        read_all("reset_x5", 5, 32'h0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        wr(1'b0, 5, 32'hDEADBEEF);
        read_all("x5_clean", 5, 32'hDEADBEEF, 1'b0, 1'b0);

        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h1;
        we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h2;
        tick();
        we_a = 1'b0; we_b = 1'b0;
        read_all("x3_b_wins", 3, 32'h2, 1'b0, 1'b0);
        wr(1'b0, 0, 32'hFFFFFFFF);
        read_all("x0_zero", 0, 32'h0, 1'b0, 1'b0);

        wr(1'b0, 7, 32'h12345678);
        wr(1'b1, 9, 32'h0F0F0F0F);
        wr(1'b0, 11, 32'h55);
        wr(1'b0, 15, 32'h15);
        wr(1'b0, 17, 32'h17);

        // Injection colliding with a write to the same entry is dropped.
        inj_en = 1'b1; inj_addr = 5'd13; inj_mask = 39'h8;
        we_a = 1'b1; waddr_a = 5'd13; wdata_a = 32'h13;
        tick();
        inj_en = 1'b0; we_a = 1'b0;
        read_all("x13_inj_drop", 13, 32'h13, 1'b0, 1'b0);

        inject(5, 39'h20);
        read_all("x5_sec", 5, 32'hDEADBEEF, 1'b1, 1'b0);
        inject(7, 39'h28);
        read_all("x7_ded", 7, 32'h1234567B, 1'b0, 1'b1);
        inject(11, 39'h1);
        read_all("x11_par", 11, 32'h55, 1'b1, 1'b0);
        inject(9, 39'h40);
        read_all("x9_sec", 9, 32'h0F0F0F0F, 1'b1, 1'b0);
        inject(13, 39'h8);
        read_all("x13_sec", 13, 32'h13, 1'b1, 1'b0);
        inject(15, 39'h80);
        inject(17, 39'h200);

        scrub_en = 1'b1;
        wait_visit(5);
        check_status("chk5", 1, 0, 0, 0, 0);
        tick();
        check_status("fix5", 1, 1, 0, 0, 0);
        read_all("x5_in_fix", 5, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        check_status("after5", 0, 1, 0, 0, 0);
        read_all("x5_fixed", 5, 32'hDEADBEEF, 1'b0, 1'b0);

        wait_visit(7);
        tick();
        check_status("after7", 0, 1, 1, 1, 7);
        read_all("x7_kept", 7, 32'h1234567B, 1'b0, 1'b1);

        wait_visit(9);
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hA5A5A5A5;
        tick();
        we_a = 1'b0;
        check_status("after9", 0, 2, 1, 1, 7);
        read_all("x9_write_wins", 9, 32'hA5A5A5A5, 1'b0, 1'b0);

        wait_visit(11);
        tick();
        tick();
        check_status("after11", 0, 3, 1, 1, 7);
        read_all("x11_fixed", 11, 32'h55, 1'b0, 1'b0);

        wait_visit(13);
        tick();
        tick();
        check_status("sat13", 0, 3, 1, 1, 7);
        read_all("x13_fixed", 13, 32'h13, 1'b0, 1'b0);

        wait_visit(15);
        tick();
        we_b = 1'b1; waddr_b = 5'd15; wdata_b = 32'h77;
        tick();
        we_b = 1'b0;
        read_all("x15_fix_drop", 15, 32'h77, 1'b0, 1'b0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_status("clr", 0, 0, 0, 0, 0);

        wait_visit(17);
        tick();
        check_status("fix17", 1, 1, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check_status("rst_in_fix", 0, 0, 0, 0, 0);
        read_all("x17_rst", 17, 32'h0, 1'b0, 1'b0);
        read_all("x5_rst", 5, 32'h0, 1'b0, 1'b0);
        scrub_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        mptr = 1; busy_q = 1'b0;
        tick();
        tick();
        check_status("post_rst", 0, 0, 0, 0, 0);
        read_all("x17_post", 17, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
